// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the MIPS program-loader encoder.
// Optional feature macro: ENC_SHIFT_EN (enables sll/srl/sra encoding).
package instr_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SLT  = 5'd4,
    OP_SLTU = 5'd5,
    OP_ADDU = 5'd6,
    OP_SUBU = 5'd7,
    OP_NOR  = 5'd8,
    OP_SLL  = 5'd9,
    OP_SRL  = 5'd10,
    OP_SRA  = 5'd11,
    OP_JR   = 5'd12,
    OP_JALR = 5'd13,
    OP_ADDI = 5'd14,
    OP_ORI  = 5'd15,
    OP_LW   = 5'd16,
    OP_SW   = 5'd17,
    OP_BEQ  = 5'd18,
    OP_BNE  = 5'd19,
    OP_J    = 5'd20,
    OP_JAL  = 5'd21
  } req_op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] pack_j(input logic [5:0] opc, input logic [25:0] tgt);
    return {opc, tgt};
  endfunction

endpackage

// File: rtl/instr_enc_core.sv
// Combinational field packer: turns one request into a 32-bit MIPS word plus a legal flag.
// ENC_SHIFT_EN selects whether sll/srl/sra and the shamt field are supported.
module instr_enc_core
  import instr_enc_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  logic [4:0] sh;

`ifdef ENC_SHIFT_EN
  assign sh = shamt_i;
`else
  // Without shift support the shamt field is always emitted as zero.
  logic unused_shamt;
  assign unused_shamt = ^shamt_i;
  assign sh = 5'd0;
`endif

  always_comb begin
    word_o  = 32'd0;
    legal_o = 1'b1;
    case (op_i)
      OP_ADD:  word_o = pack_r(rs_i, rt_i, rd_i, sh, FN_ADD);
      OP_SUB:  word_o = pack_r(rs_i, rt_i, rd_i, sh, FN_SUB);
      OP_AND:  word_o = pack_r(rs_i, rt_i, rd_i, sh, FN_AND);
      OP_OR:   word_o = pack_r(rs_i, rt_i, rd_i, sh, FN_OR);
      OP_SLT:  word_o = pack_r(rs_i, rt_i, rd_i, sh, FN_SLT);
      OP_SLTU: word_o = pack_r(rs_i, rt_i, rd_i, sh, FN_SLTU);
      OP_ADDU: word_o = pack_r(rs_i, rt_i, rd_i, sh, FN_ADDU);
      OP_SUBU: word_o = pack_r(rs_i, rt_i, rd_i, sh, FN_SUBU);
      OP_NOR:  word_o = pack_r(rs_i, rt_i, rd_i, sh, FN_NOR);
`ifdef ENC_SHIFT_EN
      OP_SLL:  word_o = pack_r(5'd0, rt_i, rd_i, sh, FN_SLL);
      OP_SRL:  word_o = pack_r(5'd0, rt_i, rd_i, sh, FN_SRL);
      OP_SRA:  word_o = pack_r(5'd0, rt_i, rd_i, sh, FN_SRA);
`endif
      OP_JR:   word_o = pack_r(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_JALR: word_o = pack_r(rs_i, 5'd0, rd_i, 5'd0, FN_JALR);
      OP_ADDI: word_o = pack_i(OPC_ADDI, rs_i, rt_i, imm_i);
      OP_ORI:  word_o = pack_i(OPC_ORI, rs_i, rt_i, imm_i);
      OP_LW:   word_o = pack_i(OPC_LW, rs_i, rt_i, imm_i);
      OP_SW:   word_o = pack_i(OPC_SW, rs_i, rt_i, imm_i);
      OP_BEQ:  word_o = pack_i(OPC_BEQ, rs_i, rt_i, imm_i);
      OP_BNE:  word_o = pack_i(OPC_BNE, rs_i, rt_i, imm_i);
      OP_J:    word_o = pack_j(OPC_J, target_i);
      OP_JAL:  word_o = pack_j(OPC_JAL, target_i);
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts encode requests, writes packed MIPS words into instruction memory.
// Shift encoding is controlled by the ENC_SHIFT_EN macro (see instr_enc_core).
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              finish_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_op_i,
  input  logic [4:0]        req_rs_i,
  input  logic [4:0]        req_rt_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_shamt_i,
  input  logic [15:0]       req_imm_i,
  input  logic [25:0]       req_target_i,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;

  instr_enc_core u_core (
    .op_i     (req_op_i),
    .rs_i     (req_rs_i),
    .rt_i     (req_rt_i),
    .rd_i     (req_rd_i),
    .shamt_i  (req_shamt_i),
    .imm_i    (req_imm_i),
    .target_i (req_target_i),
    .word_o   (enc_word),
    .legal_o  (enc_legal)
  );

  assign req_ready_o = (state_q == ST_RUN) & ~finish_i;
  assign accept      = req_valid_i & req_ready_o;

  // Write staging first; FSM control below may override counter and state.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    we_d      = 1'b0;
    im_addr_d = im_addr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (accept) begin
      if (enc_legal) begin
        we_d      = 1'b1;
        im_addr_d = addr_q;
        wdata_d   = enc_word;
        if (addr_q == ADDR_MAX) begin
          state_d = ST_FULL;
        end else begin
          addr_d = addr_q + 1'b1;
        end
        if (count_q != COUNT_MAX) begin
          count_d = count_q + 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          addr_d  = base_addr_i;
          count_d = '0;
        end
      end
      ST_RUN, ST_FULL: begin
        if (finish_i) begin
          state_d = ST_DRAIN;
        end else if (start_i) begin
          state_d = ST_RUN;
          addr_d  = base_addr_i;
          count_d = '0;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      im_addr_q <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      im_addr_q <= im_addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign im_we_o    = we_q;
  assign im_addr_o  = im_addr_q;
  assign im_wdata_o = wdata_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance plus a 4-word instance for fill-up.
// Expected words are hand-packed MIPS encodings; shift checks follow ENC_SHIFT_EN.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, finish, reqValid;
  logic [9:0]  baseAddr;
  logic [4:0]  reqOp, reqRs, reqRt, reqRd, reqShamt;
  logic [15:0] reqImm;
  logic [25:0] reqTarget;

  logic        reqReady, imWe, done, err;
  logic [9:0]  imAddr;
  logic [31:0] imWdata;
  logic [10:0] count;

  logic        sReqReady, sImWe, sDone, sErr;
  logic [1:0]  sImAddr;
  logic [31:0] sImWdata;
  logic [2:0]  sCount;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(baseAddr), .finish_i(finish),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_op_i(reqOp), .req_rs_i(reqRs),
    .req_rt_i(reqRt), .req_rd_i(reqRd), .req_shamt_i(reqShamt), .req_imm_i(reqImm),
    .req_target_i(reqTarget), .im_we_o(imWe), .im_addr_o(imAddr), .im_wdata_o(imWdata),
    .done_o(done), .err_o(err), .count_o(count)
  );

  instr_encoder #(.ADDR_W(2)) dutSmall (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(baseAddr[1:0]), .finish_i(finish),
    .req_valid_i(reqValid), .req_ready_o(sReqReady), .req_op_i(reqOp), .req_rs_i(reqRs),
    .req_rt_i(reqRt), .req_rd_i(reqRd), .req_shamt_i(reqShamt), .req_imm_i(reqImm),
    .req_target_i(reqTarget), .im_we_o(sImWe), .im_addr_o(sImAddr), .im_wdata_o(sImWdata),
    .done_o(sDone), .err_o(sErr), .count_o(sCount)
  );

  task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] sh,
                               input logic [15:0] imm, input logic [25:0] tgt);
    reqOp = op; reqRs = rs; reqRt = rt; reqRd = rd; reqShamt = sh;
    reqImm = imm; reqTarget = tgt; reqValid = 1'b1;
  endtask

  task automatic doReset();
    rst = 1'b1; start = 1'b0; finish = 1'b0; reqValid = 1'b0; baseAddr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulseStart(input logic [9:0] base);
    baseAddr = base; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (reqReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got %b want 0", reqReady); end
    checks++; if (imWe !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got %b want 0", imWe); end
    checks++; if (imAddr !== 10'd0) begin failures++; $display("[TB] FAIL reset_addr got %0d want 0", imAddr); end
    checks++; if (imWdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_wdata got %h want 0", imWdata); end
    checks++; if ({done, err} !== 2'b00) begin failures++; $display("[TB] FAIL reset_done_err got %b want 00", {done, err}); end
    checks++; if (count !== 11'd0) begin failures++; $display("[TB] FAIL reset_count got %0d want 0", count); end
  endtask

  task automatic test_encode();
    logic [4:0]  ops  [6] = '{OP_SW, OP_LW, OP_ORI, OP_JR, OP_JALR, OP_JAL};
    logic [4:0]  rsT  [6] = '{5'd29, 5'd4, 5'd2, 5'd31, 5'd4, 5'd0};
    logic [4:0]  rtT  [6] = '{5'd8, 5'd5, 5'd3, 5'd5, 5'd5, 5'd0};
    logic [4:0]  rdT  [6] = '{5'd0, 5'd0, 5'd0, 5'd6, 5'd31, 5'd0};
    logic [4:0]  shT  [6] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd3, 5'd0};
    logic [15:0] immT [6] = '{16'hFFFC, 16'h0010, 16'hABCD, 16'h0, 16'h0, 16'h0};
    logic [25:0] tgtT [6] = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h3FFFFFF};
    logic [31:0] expW [6] = '{32'hAFA8FFFC, 32'h8C850010, 32'h3443ABCD,
                              32'h03E00008, 32'h0080F809, 32'h0FFFFFFF};
    doReset();
    pulseStart(10'd0);
    applyStimulus(OP_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0);
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (imWe !== 1'b1) begin failures++; $display("[TB] FAIL addi_we got %b want 1", imWe); end
    checks++; if (imAddr !== 10'd0) begin failures++; $display("[TB] FAIL addi_addr got %0d want 0", imAddr); end
    checks++; if (imWdata !== 32'h20080005) begin failures++; $display("[TB] FAIL addi_data got %h want 20080005", imWdata); end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(ops[i], rsT[i], rtT[i], rdT[i], shT[i], immT[i], tgtT[i]);
      @(negedge clk);
      reqValid = 1'b0;
      checks++; if (imWe !== 1'b1) begin failures++; $display("[TB] FAIL enc%0d_we got %b want 1", i, imWe); end
      checks++; if (imAddr !== 10'(i + 1)) begin failures++; $display("[TB] FAIL enc%0d_addr got %0d want %0d", i, imAddr, i + 1); end
      checks++; if (imWdata !== expW[i]) begin failures++; $display("[TB] FAIL enc%0d_data got %h want %h", i, imWdata, expW[i]); end
      @(negedge clk);
      checks++; if (imWe !== 1'b0) begin failures++; $display("[TB] FAIL enc%0d_idle_we got %b want 0", i, imWe); end
    end
    checks++; if (count !== 11'd7) begin failures++; $display("[TB] FAIL enc_count got %0d want 7", count); end
  endtask

  task automatic test_back_to_back();
    doReset();
    pulseStart(10'd5);
    applyStimulus(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    checks++; if ({imWe, imAddr} !== {1'b1, 10'd5}) begin failures++; $display("[TB] FAIL b2b_add_addr got %b/%0d want 1/5", imWe, imAddr); end
    checks++; if (imWdata !== 32'h00221820) begin failures++; $display("[TB] FAIL b2b_add_data got %h want 00221820", imWdata); end
    applyStimulus(OP_NOR, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    checks++; if ({imWe, imAddr} !== {1'b1, 10'd6}) begin failures++; $display("[TB] FAIL b2b_nor_addr got %b/%0d want 1/6", imWe, imAddr); end
    checks++; if (imWdata !== 32'h00221827) begin failures++; $display("[TB] FAIL b2b_nor_data got %h want 00221827", imWdata); end
    applyStimulus(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0003, 26'h0);
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if ({imWe, imAddr} !== {1'b1, 10'd7}) begin failures++; $display("[TB] FAIL b2b_beq_addr got %b/%0d want 1/7", imWe, imAddr); end
    checks++; if (imWdata !== 32'h10220003) begin failures++; $display("[TB] FAIL b2b_beq_data got %h want 10220003", imWdata); end
    @(negedge clk);
    checks++; if (imWe !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_we got %b want 0", imWe); end
    checks++; if (count !== 11'd3) begin failures++; $display("[TB] FAIL b2b_count got %0d want 3", count); end
  endtask

  task automatic test_illegal_op();
    doReset();
    pulseStart(10'd0);
    applyStimulus(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
    @(negedge clk);
    checks++; if (imWdata !== 32'h08100000) begin failures++; $display("[TB] FAIL j_data got %h want 08100000", imWdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL j_err got %b want 0", err); end
    applyStimulus(5'd25, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (imWe !== 1'b0) begin failures++; $display("[TB] FAIL ill_we got %b want 0", imWe); end
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL ill_err got %b want 1", err); end
    checks++; if (count !== 11'd1) begin failures++; $display("[TB] FAIL ill_count got %0d want 1", count); end
    applyStimulus(OP_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001, 26'h0);
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if ({imWe, imAddr} !== {1'b1, 10'd1}) begin failures++; $display("[TB] FAIL ill_next_addr got %b/%0d want 1/1", imWe, imAddr); end
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL ill_sticky got %b want 1", err); end
  endtask

  task automatic test_shift();
    doReset();
    pulseStart(10'd0);
    applyStimulus(OP_SLL, 5'd9, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
    @(negedge clk);
    reqValid = 1'b0;
`ifdef ENC_SHIFT_EN
    checks++; if ({imWe, err} !== 2'b10) begin failures++; $display("[TB] FAIL sll_we_err got %b want 10", {imWe, err}); end
    checks++; if (imWdata !== 32'h00011100) begin failures++; $display("[TB] FAIL sll_data got %h want 00011100", imWdata); end
`else
    checks++; if ({imWe, err} !== 2'b01) begin failures++; $display("[TB] FAIL sll_we_err got %b want 01", {imWe, err}); end
    checks++; if (count !== 11'd0) begin failures++; $display("[TB] FAIL sll_count got %0d want 0", count); end
`endif
    doReset();
    pulseStart(10'd0);
    applyStimulus(OP_SRL, 5'd0, 5'd3, 5'd4, 5'd1, 16'h0, 26'h0);
    @(negedge clk);
    reqValid = 1'b0;
`ifdef ENC_SHIFT_EN
    checks++; if (imWdata !== 32'h00032042) begin failures++; $display("[TB] FAIL srl_data got %h want 00032042", imWdata); end
`else
    checks++; if ({imWe, err} !== 2'b01) begin failures++; $display("[TB] FAIL srl_we_err got %b want 01", {imWe, err}); end
`endif
  endtask

  task automatic test_finish();
    doReset();
    pulseStart(10'd0);
    applyStimulus(OP_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0);
    finish = 1'b1;
    #1;
    checks++; if (reqReady !== 1'b0) begin failures++; $display("[TB] FAIL fin_ready got %b want 0", reqReady); end
    @(negedge clk);
    finish = 1'b0; reqValid = 1'b0;
    checks++; if ({imWe, count} !== {1'b0, 11'd0}) begin failures++; $display("[TB] FAIL fin_noaccept got %b/%0d want 0/0", imWe, count); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL fin_done_early got %b want 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL fin_done got %b want 1", done); end
    @(negedge clk);
    checks++; if ({done, reqReady} !== 2'b00) begin failures++; $display("[TB] FAIL fin_idle got %b want 00", {done, reqReady}); end
  endtask

  task automatic test_reset_mid_load();
    doReset();
    pulseStart(10'd3);
    applyStimulus(OP_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0);
    @(negedge clk);
    checks++; if ({imWe, imAddr} !== {1'b1, 10'd3}) begin failures++; $display("[TB] FAIL rst_pre_we got %b/%0d want 1/3", imWe, imAddr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; reqValid = 1'b0;
    checks++; if (imWe !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_we got %b want 0", imWe); end
    checks++; if ({imAddr, imWdata} !== 42'd0) begin failures++; $display("[TB] FAIL rst_mid_addr_data got %0d/%h want 0/0", imAddr, imWdata); end
    checks++; if ({count, reqReady, done, err} !== 14'd0) begin failures++; $display("[TB] FAIL rst_mid_state got %0d/%b%b%b want 0/000", count, reqReady, done, err); end
  endtask

  task automatic test_full();
    doReset();
    pulseStart(10'd2);
    applyStimulus(OP_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001, 26'h0);
    @(negedge clk);
    checks++; if ({sImWe, sImAddr} !== {1'b1, 2'd2}) begin failures++; $display("[TB] FAIL full_w0 got %b/%0d want 1/2", sImWe, sImAddr); end
    checks++; if (sImWdata !== 32'h20010001) begin failures++; $display("[TB] FAIL full_data got %h want 20010001", sImWdata); end
    @(negedge clk);
    checks++; if ({sImWe, sImAddr} !== {1'b1, 2'd3}) begin failures++; $display("[TB] FAIL full_w1 got %b/%0d want 1/3", sImWe, sImAddr); end
    checks++; if (sReqReady !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got %b want 0", sReqReady); end
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (sImWe !== 1'b0) begin failures++; $display("[TB] FAIL full_stall_we got %b want 0", sImWe); end
    checks++; if (sCount !== 3'd2) begin failures++; $display("[TB] FAIL full_count got %0d want 2", sCount); end
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    checks++; if (sDone !== 1'b0) begin failures++; $display("[TB] FAIL full_done_early got %b want 0", sDone); end
    @(negedge clk);
    checks++; if (sDone !== 1'b1) begin failures++; $display("[TB] FAIL full_done got %b want 1", sDone); end
    @(negedge clk);
    checks++; if ({sDone, sReqReady} !== 2'b00) begin failures++; $display("[TB] FAIL full_idle got %b want 00", {sDone, sReqReady}); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; reqValid = 1'b0; baseAddr = '0;
    reqOp = '0; reqRs = '0; reqRt = '0; reqRd = '0; reqShamt = '0; reqImm = '0; reqTarget = '0;
    @(negedge clk);
    test_reset();
    test_encode();
    test_back_to_back();
    test_illegal_op();
    test_shift();
    test_finish();
    test_reset_mid_load();
    test_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
